// File: rtl/adc_writer_pkg.sv
// rtl/adc_writer_pkg.sv - shared constants for the ADC sample writer
// Purpose: FSM state encoding, status word bit positions and a pointer width helper.
// Ports: none (package).
package adc_writer_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WR_SAMPLE = 2'd1;
  localparam logic [1:0] ST_WR_STATUS = 2'd2;

  localparam int OVF_BIT     = 31;
  localparam int WRAP_BIT    = 30;
  localparam int CNT_LSB     = 16;
  localparam int CNT_FIELD_W = 14;
  localparam int PTR_LSB     = 0;
  localparam int PTR_FIELD_W = 16;

  function automatic int ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/adc_sample_writer_if.sv
// rtl/adc_sample_writer_if.sv - RAM port-B write bus between the ADC writer and the data RAM
// Purpose: bundles the write-only RAM port signals.
// Ports: adc_wEn (write enable), adc_addr (word address), adc_dataIn (write data).
//   master = writer side (drives), slave = RAM side (receives).
interface adc_sample_writer_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
);
  logic                     adc_wEn;
  logic [ADDRESS_WIDTH-1:0] adc_addr;
  logic [DATA_WIDTH-1:0]    adc_dataIn;

  modport master (output adc_wEn, output adc_addr, output adc_dataIn);
  modport slave  (input  adc_wEn, input  adc_addr, input  adc_dataIn);
endinterface

// File: rtl/adc_pend_slot.sv
// rtl/adc_pend_slot.sv - one-entry holding register for ADC samples with drop accounting
// Purpose: holds one pending sample until the FSM consumes it; counts strobes that find it full.
// Ports: clk, reset_n; clear_i (sync clear), load_i (qualified strobe), data_i (sample),
//   consume_i (FSM takes the slot this edge); valid_o/data_o (slot contents),
//   drop_o (strobe lost this cycle), drop_count_o (saturating), overflow_o (sticky).
module adc_pend_slot #(
  parameter int SAMPLE_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear_i,
  input  logic                    load_i,
  input  logic [SAMPLE_WIDTH-1:0] data_i,
  input  logic                    consume_i,
  output logic                    valid_o,
  output logic [SAMPLE_WIDTH-1:0] data_o,
  output logic                    drop_o,
  output logic [15:0]             drop_count_o,
  output logic                    overflow_o
);

  logic                    valid_q, valid_d;
  logic [SAMPLE_WIDTH-1:0] data_q, data_d;
  logic [15:0]             drop_cnt_q, drop_cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    accept;

  // A slot being consumed on this edge counts as free, so back-to-back samples are not lost.
  assign accept = load_i && !clear_i && (!valid_q || consume_i);
  assign drop_o = load_i && !clear_i && valid_q && !consume_i;

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;
    if (clear_i) begin
      valid_d    = 1'b0;
      drop_cnt_d = '0;
      ovf_d      = 1'b0;
    end else begin
      if (accept) begin
        valid_d = 1'b1;
        data_d  = data_i;
      end else if (consume_i) begin
        valid_d = 1'b0;
      end
      if (drop_o) begin
        ovf_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign drop_count_o = drop_cnt_q;
  assign overflow_o   = ovf_q;

endmodule

// File: rtl/adc_sample_writer.sv
// rtl/adc_sample_writer.sv - writes tagged ADC samples into a RAM ring buffer plus a status word
// Purpose: per accepted sample, one ring-buffer write followed by one status write to STATUS_ADDR.
// Ports: clk, reset_n (async, active low); enable, clear, sample_stb, sample_data (ADC side);
//   ram (write bus, master); wrPtr, sampleCount, dropCount, overflow, wrapped (progress/status).
module adc_sample_writer
  import adc_writer_pkg::*;
#(
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       ADDRESS_WIDTH = 12,
  parameter int                       SAMPLE_WIDTH  = 12,
  parameter logic [ADDRESS_WIDTH-1:0] BUF_BASE      = 12'h800,
  parameter int                       BUF_DEPTH     = 1024,
  parameter logic [ADDRESS_WIDTH-1:0] STATUS_ADDR   = 12'hFFF
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               enable,
  input  logic                               clear,
  input  logic                               sample_stb,
  input  logic [SAMPLE_WIDTH-1:0]            sample_data,
  adc_sample_writer_if.master                ram,
  output logic [ptr_width(BUF_DEPTH)-1:0]    wrPtr,
  output logic [31:0]                        sampleCount,
  output logic [15:0]                        dropCount,
  output logic                               overflow,
  output logic                               wrapped
);

  localparam int PTR_W = ptr_width(BUF_DEPTH);
  localparam int BASE_I = int'(BUF_BASE);
  localparam int STAT_I = int'(STATUS_ADDR);

  if ((BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("BUF_DEPTH must be a power of two");
  end
  if ((BASE_I % BUF_DEPTH) != 0) begin : g_chk_align
    $error("BUF_BASE must be aligned to BUF_DEPTH");
  end
  if (STAT_I >= BASE_I && STAT_I < BASE_I + BUF_DEPTH) begin : g_chk_status
    $error("STATUS_ADDR must lie outside the ring buffer");
  end
  if (SAMPLE_WIDTH >= DATA_WIDTH || DATA_WIDTH < 32) begin : g_chk_width
    $error("need SAMPLE_WIDTH < DATA_WIDTH and DATA_WIDTH >= 32");
  end

  logic [1:0]               state_q, state_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d, ptr_inc;
  logic [31:0]              cnt_q, cnt_d, cnt_inc;
  logic                     wrap_q, wrap_d, wrap_next;
  logic                     wen_q, wen_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d, sample_addr;
  logic [DATA_WIDTH-1:0]    data_q, data_d, sample_word, status_word;

  logic                     slot_valid, slot_consume, slot_drop, slot_ovf;
  logic [SAMPLE_WIDTH-1:0]  slot_data;

  // The slot empties on the edge that starts a sample write.
  assign slot_consume = !clear && slot_valid &&
                        (state_q == ST_IDLE || state_q == ST_WR_STATUS);

  adc_pend_slot #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) u_slot (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear_i      (clear),
    .load_i       (enable && sample_stb),
    .data_i       (sample_data),
    .consume_i    (slot_consume),
    .valid_o      (slot_valid),
    .data_o       (slot_data),
    .drop_o       (slot_drop),
    .drop_count_o (dropCount),
    .overflow_o   (slot_ovf)
  );

  // Output registers are loaded on the edge entering a write state, so the status word
  // is built from the post-increment pointer/count and includes a drop happening this cycle.
  assign ptr_inc     = ptr_q + 1'b1;
  assign cnt_inc     = cnt_q + 32'd1;
  assign wrap_next   = wrap_q | (&ptr_q);
  assign sample_addr = BUF_BASE | ADDRESS_WIDTH'(ptr_q);
  assign sample_word = {cnt_q[DATA_WIDTH-SAMPLE_WIDTH-1:0], slot_data};

  always_comb begin
    status_word = '0;
    status_word[OVF_BIT]                   = slot_ovf | slot_drop;
    status_word[WRAP_BIT]                  = wrap_next;
    status_word[CNT_LSB +: CNT_FIELD_W]    = cnt_inc[CNT_FIELD_W-1:0];
    status_word[PTR_LSB +: PTR_FIELD_W]    = PTR_FIELD_W'(ptr_inc);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wrap_d  = wrap_q;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    if (clear) begin
      state_d = ST_IDLE;
      ptr_d   = '0;
      cnt_d   = '0;
      wrap_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_WR_STATUS: begin
          if (slot_valid) begin
            state_d = ST_WR_SAMPLE;
            wen_d   = 1'b1;
            addr_d  = sample_addr;
            data_d  = sample_word;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WR_SAMPLE: begin
          state_d = ST_WR_STATUS;
          ptr_d   = ptr_inc;
          cnt_d   = cnt_inc;
          wrap_d  = wrap_next;
          wen_d   = 1'b1;
          addr_d  = STATUS_ADDR;
          data_d  = status_word;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign ram.adc_wEn    = wen_q;
  assign ram.adc_addr   = addr_q;
  assign ram.adc_dataIn = data_q;
  assign wrPtr          = ptr_q;
  assign sampleCount    = cnt_q;
  assign overflow       = slot_ovf;
  assign wrapped        = wrap_q;

endmodule

// File: tb/tb_adc_sample_writer.sv
// tb/tb_adc_sample_writer.sv - self-checking bench for adc_sample_writer
module tb_adc_sample_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        clear;
  logic        sample_stb;
  logic [11:0] sample_data;
  logic [9:0]  wrPtr;
  logic [31:0] sampleCount;
  logic [15:0] dropCount;
  logic        overflow;
  logic        wrapped;

  int n_tests = 0;
  int n_fail  = 0;

  adc_sample_writer_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12)) ram_if ();

  adc_sample_writer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .clear       (clear),
    .sample_stb  (sample_stb),
    .sample_data (sample_data),
    .ram         (ram_if),
    .wrPtr       (wrPtr),
    .sampleCount (sampleCount),
    .dropCount   (dropCount),
    .overflow    (overflow),
    .wrapped     (wrapped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] data;
    logic [11:0] addr;
    logic [31:0] sword;
    logic [31:0] status;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [11:0] d);
    sample_stb  = 1'b1;
    sample_data = d;
    tick();
    sample_stb  = 1'b0;
  endtask

  initial begin
    int bad;
    reset_n = 1'b0; enable = 1'b1; clear = 1'b0; sample_stb = 1'b0; sample_data = '0;

    vecs[0] = '{12'hABC, 12'h800, 32'h0000_0ABC, 32'h0001_0001};
    vecs[1] = '{12'h123, 12'h801, 32'h0000_1123, 32'h0002_0002};
    vecs[2] = '{12'hFFF, 12'h802, 32'h0000_2FFF, 32'h0003_0003};
    vecs[3] = '{12'h000, 12'h803, 32'h0000_3000, 32'h0004_0004};

    #1;
    chk("rst_wen",  {31'd0, ram_if.adc_wEn}, 32'd0);
    chk("rst_addr", {20'd0, ram_if.adc_addr}, 32'd0);
    chk("rst_data", ram_if.adc_dataIn, 32'd0);
    chk("rst_cnt",  sampleCount, 32'd0);
    chk("rst_flags", {wrPtr, dropCount, overflow, wrapped}, 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Single isolated samples: sample write, status write, then idle.
    for (int i = 0; i < 4; i++) begin
      strobe(vecs[i].data);
      tick();
      chk("vec_s_wen",  {31'd0, ram_if.adc_wEn}, 32'd1);
      chk("vec_s_addr", {20'd0, ram_if.adc_addr}, {20'd0, vecs[i].addr});
      chk("vec_s_data", ram_if.adc_dataIn, vecs[i].sword);
      tick();
      chk("vec_st_wen",  {31'd0, ram_if.adc_wEn}, 32'd1);
      chk("vec_st_addr", {20'd0, ram_if.adc_addr}, 32'hFFF);
      chk("vec_st_data", ram_if.adc_dataIn, vecs[i].status);
      tick();
      chk("vec_idle_wen", {31'd0, ram_if.adc_wEn}, 32'd0);
    end

    // Clear during WR_SAMPLE abandons the write and zeroes everything.
    strobe(12'h555);
    tick();
    chk("clr_pre_wen", {31'd0, ram_if.adc_wEn}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_wen",   {31'd0, ram_if.adc_wEn}, 32'd0);
    chk("clr_cnt",   sampleCount, 32'd0);
    chk("clr_flags", {wrPtr, dropCount, overflow, wrapped}, 32'd0);
    tick();
    chk("clr_idle_wen", {31'd0, ram_if.adc_wEn}, 32'd0);
    strobe(12'h777);
    tick();
    chk("clr_s_addr", {20'd0, ram_if.adc_addr}, 32'h800);
    chk("clr_s_data", ram_if.adc_dataIn, 32'h0000_0777);
    tick();
    chk("clr_st_data", ram_if.adc_dataIn, 32'h0001_0001);
    tick();

    // Three strobes on consecutive cycles: the third finds the slot full.
    sample_stb = 1'b1; sample_data = 12'h111; tick();
    sample_data = 12'h222; tick();
    chk("drp_a_addr", {20'd0, ram_if.adc_addr}, 32'h801);
    chk("drp_a_data", ram_if.adc_dataIn, 32'h0000_1111);
    sample_data = 12'h333; tick();
    sample_stb = 1'b0;
    chk("drp_st1", ram_if.adc_dataIn, 32'h8002_0002);
    tick();
    chk("drp_b_addr", {20'd0, ram_if.adc_addr}, 32'h802);
    chk("drp_b_data", ram_if.adc_dataIn, 32'h0000_2222);
    tick();
    chk("drp_st2", ram_if.adc_dataIn, 32'h8003_0003);
    tick();
    chk("drp_idle_wen", {31'd0, ram_if.adc_wEn}, 32'd0);
    chk("drp_count", {16'd0, dropCount}, 32'd1);
    chk("drp_ovf",   {31'd0, overflow}, 32'd1);
    chk("drp_scnt",  sampleCount, 32'd3);

    // enable low: strobes ignored and not counted as drops.
    clear = 1'b1; tick(); clear = 1'b0;
    enable = 1'b0;
    sample_stb = 1'b1; sample_data = 12'h5A5;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("dis_wen", {31'd0, ram_if.adc_wEn}, 32'd0);
    end
    sample_stb = 1'b0;
    chk("dis_drop", {16'd0, dropCount}, 32'd0);
    chk("dis_scnt", sampleCount, 32'd0);

    // enable falls during WR_SAMPLE: status write still completes.
    enable = 1'b1;
    strobe(12'h444);
    tick();
    chk("enf_s_data", ram_if.adc_dataIn, 32'h0000_0444);
    enable = 1'b0;
    tick();
    chk("enf_st_wen",  {31'd0, ram_if.adc_wEn}, 32'd1);
    chk("enf_st_addr", {20'd0, ram_if.adc_addr}, 32'hFFF);
    chk("enf_st_data", ram_if.adc_dataIn, 32'h0001_0001);
    tick();
    enable = 1'b1;

    // Asynchronous reset in the middle of WR_STATUS.
    strobe(12'h999);
    tick();
    tick();
    chk("ar_pre_wen", {31'd0, ram_if.adc_wEn}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_wen",   {31'd0, ram_if.adc_wEn}, 32'd0);
    chk("ar_addr",  {20'd0, ram_if.adc_addr}, 32'd0);
    chk("ar_data",  ram_if.adc_dataIn, 32'd0);
    chk("ar_cnt",   sampleCount, 32'd0);
    chk("ar_flags", {wrPtr, dropCount, overflow, wrapped}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    tick();
    chk("ar_idle_wen", {31'd0, ram_if.adc_wEn}, 32'd0);

    // Sustained rate: 1025 samples, one strobe every two cycles, ring wraps once.
    bad = 0;
    for (int i = 0; i < 1025; i++) begin
      strobe(12'(i));
      tick();
      if (ram_if.adc_wEn !== 1'b1 ||
          ram_if.adc_addr !== (12'h800 | 12'(i % 1024)) ||
          ram_if.adc_dataIn !== {20'(i), 12'(i)})
        bad++;
    end
    chk("sus_sample_writes", bad, 0);
    chk("sus_last_data", ram_if.adc_dataIn, 32'h0040_0400);
    chk("sus_last_addr", {20'd0, ram_if.adc_addr}, 32'h800);
    tick();
    chk("sus_last_status", ram_if.adc_dataIn, 32'h4401_0001);
    tick();
    chk("sus_idle_wen", {31'd0, ram_if.adc_wEn}, 32'd0);
    chk("sus_drop",     {16'd0, dropCount}, 32'd0);
    chk("sus_wrapped",  {31'd0, wrapped}, 32'd1);
    chk("sus_wrptr",    {22'd0, wrPtr}, 32'd1);
    chk("sus_scnt",     sampleCount, 32'd1025);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
